// File: rtl/phv_stage_fifo_if.sv
// Bus bundle for the elastic PHV buffer: valid-only ingress, valid/ready egress, status and drop counter.
// Egress handshake: a PHV transfers on a rising edge where phv_out_valid && phv_out_ready; phv_out is held while valid && !ready.
interface phv_stage_fifo_if #(
    parameter int PHV_LEN = 1124,
    parameter int DEPTH   = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               phv_out_ready;
    logic               almost_full;
    logic [OCC_W-1:0]   occupancy;
    logic [31:0]        drop_cnt;
    logic               drop_cnt_clr;

    // Upstream stage / downstream consumer side.
    modport master (
        output phv_in, phv_in_valid, phv_out_ready, drop_cnt_clr,
        input  phv_out, phv_out_valid, almost_full, occupancy, drop_cnt
    );

    // FIFO side.
    modport slave (
        input  phv_in, phv_in_valid, phv_out_ready, drop_cnt_clr,
        output phv_out, phv_out_valid, almost_full, occupancy, drop_cnt
    );
endinterface

// File: rtl/phv_stage_fifo.sv
// Elastic PHV buffer behind a match-action stage: absorbs a valid-only stream and re-presents it
// with valid/ready, flagging almost_full and counting overflow drops.
module phv_stage_fifo #(
    parameter int PHV_LEN   = 1124,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6
) (
    input  logic              axis_clk,
    input  logic              areset,
    phv_stage_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [PHV_LEN-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      rd_ptr_nxt;
    logic [OW-1:0]      occ;
    logic [OW-1:0]      occ_nxt;
    logic [PHV_LEN-1:0] head_q;
    logic               valid_q;
    logic               af_q;
    logic [31:0]        drop_q;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic head_from_in;

    always_comb begin
        full         = (occ == OW'(DEPTH));
        pop          = valid_q && bus.phv_out_ready;
        push         = bus.phv_in_valid && (!full || pop);
        drop         = bus.phv_in_valid && full && !pop;
        rd_ptr_nxt   = pop ? rd_ptr + 1'b1 : rd_ptr;
        // The pushed PHV becomes the head when nothing older survives this edge.
        head_from_in = push && ((occ == '0) || ((occ == OW'(1)) && pop));
        occ_nxt      = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
    end

    // Storage is deliberately not reset; validity is tracked by occupancy alone.
    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr] <= bus.phv_in;
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            af_q    <= 1'b0;
            drop_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_nxt;
            occ     <= occ_nxt;
            valid_q <= (occ_nxt != '0);
            af_q    <= (occ_nxt >= OW'(AF_THRESH));
            // The head is a register so phv_out never sees phv_in combinationally.
            if (head_from_in) head_q <= bus.phv_in;
            else if (pop)     head_q <= mem[rd_ptr_nxt];
            if (bus.drop_cnt_clr)               drop_q <= '0;
            else if (drop && (drop_q != '1))    drop_q <= drop_q + 1'b1;
        end
    end

    assign bus.phv_out       = head_q;
    assign bus.phv_out_valid = valid_q;
    assign bus.almost_full   = af_q;
    assign bus.occupancy     = occ;
    assign bus.drop_cnt      = drop_q;
endmodule

// File: tb/tb_phv_stage_fifo.sv
// Self-checking bench for phv_stage_fifo: directed scenarios plus random traffic against a queue model.
module tb_phv_stage_fifo;
  localparam int PHV_LEN   = 1124;
  localparam int DEPTH     = 8;
  localparam int AF_THRESH = 6;

  logic axis_clk = 1'b0;
  logic areset;

  phv_stage_fifo_if #(.PHV_LEN(PHV_LEN), .DEPTH(DEPTH)) bus ();

  phv_stage_fifo #(.PHV_LEN(PHV_LEN), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .axis_clk (axis_clk),
    .areset   (areset),
    .bus      (bus)
  );

  // clock / reset
  always #5 axis_clk = ~axis_clk;

  // scoreboard
  logic [PHV_LEN-1:0] exp_q[$];
  logic [31:0]        exp_drop;
  int                 n_checks;
  int                 n_errors;

  task automatic check(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic check_outputs();
    check("valid", PHV_LEN'(bus.phv_out_valid), PHV_LEN'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("head", bus.phv_out, exp_q[0]);
    check("occupancy", PHV_LEN'(bus.occupancy), PHV_LEN'(exp_q.size()));
    check("almost_full", PHV_LEN'(bus.almost_full), PHV_LEN'(exp_q.size() >= AF_THRESH));
    check("drop_cnt", PHV_LEN'(bus.drop_cnt), PHV_LEN'(exp_drop));
  endtask

  function automatic logic [PHV_LEN-1:0] tagged_phv(input logic [31:0] tag);
    logic [1151:0] raw;
    for (int i = 0; i < 36; i++) raw[i*32 +: 32] = $urandom;
    raw[31:0] = tag;
    return raw[PHV_LEN-1:0];
  endfunction

  // driver: called in the negedge region, drives one edge, updates model, checks after the edge
  task automatic cycle(input logic v, input logic [PHV_LEN-1:0] d, input logic r, input logic c);
    bit pop, push, drop;
    bus.phv_in_valid  = v;
    bus.phv_in        = d;
    bus.phv_out_ready = r;
    bus.drop_cnt_clr  = c;
    pop  = (exp_q.size() != 0) && r;
    push = v && ((exp_q.size() < DEPTH) || pop);
    drop = v && !push;
    @(posedge axis_clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(d);
    if (c) exp_drop = '0;
    else if (drop && exp_drop != 32'hFFFFFFFF) exp_drop = exp_drop + 1;
    @(negedge axis_clk);
    bus.phv_in_valid = 1'b0;
    bus.drop_cnt_clr = 1'b0;
    check_outputs();
  endtask

  task automatic idle_pop(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  logic [PHV_LEN-1:0] pt;
  logic [PHV_LEN-1:0] cc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_drop = '0;
    areset = 1'b1;
    bus.phv_in        = '0;
    bus.phv_in_valid  = 1'b0;
    bus.phv_out_ready = 1'b0;
    bus.drop_cnt_clr  = 1'b0;
    repeat (2) @(negedge axis_clk);
    check("rst_phv_out", bus.phv_out, '0);
    check_outputs();
    areset = 1'b0;

    // single pass-through
    pt = '0;
    for (int i = 0; i < 16; i++) pt[PHV_LEN-1-48*i -: 48] = {6{8'hff - 8'(8'h11 * i)}};
    cycle(1'b1, pt, 1'b1, 1'b0);
    check("pt_data", bus.phv_out, pt);
    check("pt_occ1", PHV_LEN'(bus.occupancy), PHV_LEN'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("pt_valid_gone", PHV_LEN'(bus.phv_out_valid), PHV_LEN'(0));

    // fill and overflow
    for (int i = 1; i <= 10; i++) cycle(1'b1, tagged_phv(32'(i)), 1'b0, 1'b0);
    check("fill_drop", PHV_LEN'(bus.drop_cnt), PHV_LEN'(2));
    check("fill_occ", PHV_LEN'(bus.occupancy), PHV_LEN'(DEPTH));
    check("fill_af", PHV_LEN'(bus.almost_full), PHV_LEN'(1));
    check("fill_head_tag", PHV_LEN'(bus.phv_out[31:0]), PHV_LEN'(1));
    idle_pop(DEPTH);

    // full with simultaneous pop
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, tagged_phv(32'(i)), 1'b0, 1'b0);
    cycle(1'b1, tagged_phv(32'd9), 1'b1, 1'b0);
    check("fp_drop", PHV_LEN'(bus.drop_cnt), PHV_LEN'(2));
    check("fp_occ", PHV_LEN'(bus.occupancy), PHV_LEN'(DEPTH));
    check("fp_head_tag", PHV_LEN'(bus.phv_out[31:0]), PHV_LEN'(2));
    idle_pop(DEPTH);

    // backpressure stability
    for (int i = 1; i <= 3; i++) cycle(1'b1, tagged_phv(32'(100 + i)), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("bp_empty", PHV_LEN'(bus.phv_out_valid), PHV_LEN'(0));

    // counter clear coinciding with a drop
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, tagged_phv(32'(200 + i)), 1'b0, 1'b0);
    cycle(1'b1, tagged_phv(32'd300), 1'b0, 1'b1);
    check("clr_drop0", PHV_LEN'(bus.drop_cnt), PHV_LEN'(0));
    cycle(1'b1, tagged_phv(32'd301), 1'b0, 1'b0);
    check("clr_drop1", PHV_LEN'(bus.drop_cnt), PHV_LEN'(1));

    // reset mid-operation with five entries stored
    idle_pop(3);
    check("pre_rst_occ", PHV_LEN'(bus.occupancy), PHV_LEN'(5));
    #2 areset = 1'b1;
    #1;
    check("rst_valid", PHV_LEN'(bus.phv_out_valid), PHV_LEN'(0));
    check("rst_occ", PHV_LEN'(bus.occupancy), PHV_LEN'(0));
    check("rst_af", PHV_LEN'(bus.almost_full), PHV_LEN'(0));
    check("rst_drop", PHV_LEN'(bus.drop_cnt), PHV_LEN'(0));
    exp_q.delete();
    exp_drop = '0;
    #1 areset = 1'b0;
    cc = tagged_phv(32'hcccccccc);
    cycle(1'b1, cc, 1'b0, 1'b0);
    check("rst_next_head", bus.phv_out, cc);
    idle_pop(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 6, tagged_phv($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 3);
    end
    idle_pop(DEPTH);
    check("final_empty", PHV_LEN'(bus.phv_out_valid), PHV_LEN'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/phv_stage_fifo.md
Name: phv_stage_fifo

Overview:
- Elastic PHV buffer placed directly downstream of a match-action stage.
- It absorbs the stage's valid-only PHV stream (phv_out/phv_out_valid, which has no backpressure) and re-presents it to the next stage or to the deparser with a valid/ready handshake.
- It raises almost_full early enough for upstream pacing, and counts any PHV dropped on overflow.

Parameters:
PHV_LEN, 1124, PHV width in bits (48*8+32*8+16*8+5*20+256).
DEPTH, 8, number of PHV entries; power of two, minimum 2.
AF_THRESH, 6, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
axis_clk  in  1  clock; all logic is on the rising edge.
areset  in  1  asynchronous active-high reset.
phv_in  in  PHV_LEN  PHV from the upstream stage.
phv_in_valid  in  1  single-cycle qualifier for phv_in; no ready is returned.
phv_out  out  PHV_LEN  head-of-FIFO PHV.
phv_out_valid  out  1  phv_out holds a valid PHV.
phv_out_ready  in  1  downstream accepts phv_out this cycle.
almost_full  out  1  occupancy >= AF_THRESH.
occupancy  out  $clog2(DEPTH)+1  entries currently stored, range 0..DEPTH.
drop_cnt  out  32  count of PHVs discarded on overflow; saturates at 32'hFFFFFFFF.
drop_cnt_clr  in  1  synchronous clear of drop_cnt.

Behaviour:
- Reset: areset asynchronously clears the following.
  - Pointers and occupancy go to 0.
  - phv_out_valid=0, almost_full=0, drop_cnt=0.
  - phv_out goes to 0.
  - Storage contents are not cleared.
  - Reset asserted mid-stream discards every stored PHV; the first push after deassertion becomes the head.
- Storage: circular buffer of DEPTH entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - occupancy is a separate registered counter.
- Push: phv_in_valid=1 at edge N writes mem[wr_ptr] and increments wr_ptr, provided the buffer is not full or a pop occurs on the same edge.
- Pop: phv_out_valid && phv_out_ready at edge N advances rd_ptr.
- Output:
  - phv_out = mem[rd_ptr].
  - phv_out_valid = (occupancy != 0).
  - Both are derived from flops only; there is no combinational path from phv_in to phv_out.
- Latency: a PHV pushed into an empty FIFO at edge N is presented with phv_out_valid=1 in the cycle after edge N. Minimum latency is 1 cycle; there is no bypass.
- Occupancy update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full (occupancy==DEPTH):
  - push with no simultaneous pop: the PHV is dropped, memory and pointers are untouched, and drop_cnt increments.
  - push with a simultaneous pop: the push is accepted and occupancy stays at DEPTH.
- Empty: phv_out_valid=0 and phv_out_ready is ignored. Push and ready together on an empty FIFO is a push only.
- almost_full is registered and equals (occupancy >= AF_THRESH) using the post-edge occupancy.
- drop_cnt priority:
  - drop_cnt_clr has priority over increment.
  - Clear and drop on the same edge gives 0.
  - At 32'hFFFFFFFF the counter holds its value.
- Ordering: strict FIFO. PHV bits pass through unmodified.
- phv_out is stable while phv_out_valid=1 and phv_out_ready=0.

Test Plan:
- Single pass-through: after reset, push one PHV {48'hffffffffffff,48'heeeeeeeeeeee,...,356'b0} with ready=1 held. Required: phv_out_valid=1 for exactly 1 cycle, starting 1 cycle after the push edge, with phv_out bit-identical to the input; occupancy 0->1->0.
- Fill and overflow: ready=0, push 10 distinct PHVs (low 32 bits = 1..10) back-to-back. Required: occupancy reaches 8; almost_full asserts after the 6th push; drop_cnt=2. Then ready=1: outputs 1..8 appear in order; almost_full clears once occupancy drops below 6.
- Full with simultaneous pop: FIFO full (1..8), push value 9 on the same edge ready=1 pops 1. Required: drop_cnt unchanged; occupancy stays 8; subsequent drain gives 2..9.
- Backpressure stability: 3 PHVs stored, toggle ready 1,0,0,1,1. Required: phv_out holds while ready=0; exactly 3 transfers in order; phv_out_valid=0 afterwards.
- Reset mid-operation: 5 PHVs stored, pulse areset between clock edges. Required: phv_out_valid, occupancy, almost_full and drop_cnt are 0 immediately. A push of 32'hcccccccc-tagged PHV afterwards is the next output.
- Counter clear: drop_cnt=2, assert drop_cnt_clr on the same edge as an overflow drop. Required: drop_cnt=0; the next overflow drop gives 1.
